// File: rtl/log_mult_accum_if.sv
// Stream bundle between the Mitchell multiplier, the log-MAC accumulator
// and its result consumer: product beats in, dot-product results out.
interface log_mult_accum_if #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned ACC_W = 40
);
    logic              i_clear;
    logic              i_valid;
    logic [IN_W-1:0]   i_prod;
    logic              o_ready;
    logic              o_valid;
    logic [ACC_W-1:0]  o_sum;
    logic              o_sat;
    logic              i_ready;

    // Producer/consumer side driving products and result backpressure
    modport master (
        output i_clear, i_valid, i_prod, i_ready,
        input  o_ready, o_valid, o_sum, o_sat
    );

    // Accumulator side
    modport slave (
        input  i_clear, i_valid, i_prod, i_ready,
        output o_ready, o_valid, o_sum, o_sat
    );
endinterface

// File: rtl/log_mult_accum.sv
// Reduction stage of the log-MAC datapath: sums LEN signed products into a
// dot-product result presented on a valid/ready port with full backpressure.
// Compile-time option LOG_MULT_ACCUM_SAT_EN: when defined every add clamps to
// the signed ACC_W range and the result carries a sticky saturation flag;
// when undefined the sum wraps modulo 2^ACC_W and o_sat stays 0.
module log_mult_accum #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned ACC_W = 40,
    parameter int unsigned LEN   = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    log_mult_accum_if.slave bus
);
    localparam int unsigned      CNT_W    = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
`ifdef LOG_MULT_ACCUM_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              sat_q, sat_d;
    logic              o_valid_q, o_valid_d;
    logic [ACC_W-1:0]  o_sum_q, o_sum_d;
    logic              o_sat_q, o_sat_d;

    logic              ready_c;
    logic              accept_c;
    logic              handoff_c;
    logic              first_c;
    logic              last_c;
    logic              ovf_c;
    logic              sat_next_c;
    logic [IN_W-1:0]   prod_c;
    logic [ACC_W-1:0]  prod_ext_c;
    logic [ACC_W-1:0]  base_c;
    logic [ACC_W:0]    sum_wide_c;
    logic [ACC_W-1:0]  add_res_c;

    assign prod_c = bus.i_prod;

    // Handshake decode and the signed add with overflow detect
    always_comb begin
        ready_c    = (state_q == S_DONE) ? bus.i_ready : 1'b1;
        accept_c   = bus.i_valid & ready_c;
        handoff_c  = (state_q == S_DONE) & bus.i_ready;
        first_c    = (cnt_q == '0);
        last_c     = (cnt_q == CNT_LAST);
        prod_ext_c = ACC_W'($signed(prod_c));
        // Element 0 of a vector loads instead of adding to the stale sum
        base_c     = first_c ? '0 : acc_q;
        sum_wide_c = {base_c[ACC_W-1], base_c} + {prod_ext_c[ACC_W-1], prod_ext_c};
        ovf_c      = sum_wide_c[ACC_W] ^ sum_wide_c[ACC_W-1];
`ifdef LOG_MULT_ACCUM_SAT_EN
        if (ovf_c) begin
            add_res_c = sum_wide_c[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            add_res_c = sum_wide_c[ACC_W-1:0];
        end
`else
        add_res_c  = sum_wide_c[ACC_W-1:0];
`endif
        sat_next_c = ovf_c | (~first_c & sat_q);
    end

    // Next-state, beat counter, accumulator and result registers
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        sat_d     = sat_q;
        o_valid_d = o_valid_q;
        o_sum_d   = o_sum_q;
        o_sat_d   = o_sat_q;
        if (bus.i_clear) begin
            // Abort wins over handoff and accept; o_sum keeps its last value
            state_d   = S_IDLE;
            cnt_d     = '0;
            acc_d     = '0;
            sat_d     = 1'b0;
            o_valid_d = 1'b0;
        end else begin
            if (handoff_c) begin
                state_d   = S_IDLE;
                o_valid_d = 1'b0;
            end
            if (accept_c) begin
                acc_d = add_res_c;
                sat_d = sat_next_c;
                if (last_c) begin
                    state_d   = S_DONE;
                    cnt_d     = '0;
                    o_valid_d = 1'b1;
                    o_sum_d   = add_res_c;
`ifdef LOG_MULT_ACCUM_SAT_EN
                    o_sat_d   = sat_next_c;
`else
                    o_sat_d   = 1'b0;
`endif
                end else begin
                    state_d = S_ACC;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            sat_q     <= 1'b0;
            o_valid_q <= 1'b0;
            o_sum_q   <= '0;
            o_sat_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            sat_q     <= sat_d;
            o_valid_q <= o_valid_d;
            o_sum_q   <= o_sum_d;
            o_sat_q   <= o_sat_d;
        end
    end

    assign bus.o_ready = ready_c;
    assign bus.o_valid = o_valid_q;
    assign bus.o_sum   = o_sum_q;
    assign bus.o_sat   = o_sat_q;

endmodule

// File: tb/tb_log_mult_accum.sv
// Scoreboard bench for log_mult_accum (ACC_W=33, LEN=4). A reference model
// pushes expected results as vectors complete; a monitor pops on handoff.
// Honours LOG_MULT_ACCUM_SAT_EN the same way the design does.
module tb_log_mult_accum;
    localparam int unsigned IN_W  = 32;
    localparam int unsigned ACC_W = 33;
    localparam int unsigned LEN   = 4;
    localparam longint ACC_MAX_V = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint ACC_MIN_V = -(longint'(1) <<< (ACC_W - 1));
    localparam longint ACC_SPAN  = longint'(1) <<< ACC_W;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        longint sum;
        bit     sat;
    } res_t;

    res_t   exp_q[$];
    longint m_acc = 0;
    int     m_cnt = 0;
    bit     m_sat = 1'b0;
    bit     m_pending = 1'b0;

    log_mult_accum_if #(.IN_W(IN_W), .ACC_W(ACC_W)) bus ();

    log_mult_accum #(.IN_W(IN_W), .ACC_W(ACC_W), .LEN(LEN)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic longint sum_now();
        return longint'($signed(bus.o_sum));
    endfunction

    // Plain-arithmetic accumulate step: clamp or wrap into the ACC_W range
    function automatic longint model_add(input longint a, input longint p, output bit clamped);
        longint r;
        r = a + p;
        clamped = 1'b0;
`ifdef LOG_MULT_ACCUM_SAT_EN
        if (r > ACC_MAX_V) begin
            r = ACC_MAX_V;
            clamped = 1'b1;
        end else if (r < ACC_MIN_V) begin
            r = ACC_MIN_V;
            clamped = 1'b1;
        end
`else
        if (r > ACC_MAX_V) r = r - ACC_SPAN;
        else if (r < ACC_MIN_V) r = r + ACC_SPAN;
`endif
        return r;
    endfunction

    // Reference model: tracks pending result, expected ready, and vector sums
    always @(negedge clk) begin
        bit     exp_ready;
        bit     cl;
        longint p;
        if (!rst_n) begin
            m_acc = 0; m_cnt = 0; m_sat = 1'b0; m_pending = 1'b0;
            exp_q.delete();
        end else begin
            exp_ready = !m_pending || bus.i_ready;
            check("o_ready", longint'(bus.o_ready), longint'(exp_ready));
            check("o_valid", longint'(bus.o_valid), longint'(m_pending));
            if (bus.i_clear) begin
                m_acc = 0; m_cnt = 0; m_sat = 1'b0; m_pending = 1'b0;
                exp_q.delete();
            end else begin
                if (m_pending && bus.i_ready) m_pending = 1'b0;
                if (bus.i_valid && exp_ready) begin
                    p = longint'($signed(bus.i_prod));
                    m_acc = model_add(m_acc, p, cl);
                    m_sat = m_sat | cl;
                    m_cnt++;
                    if (m_cnt == int'(LEN)) begin
                        exp_q.push_back('{sum: m_acc, sat: m_sat});
                        m_pending = 1'b1;
                        m_acc = 0; m_cnt = 0; m_sat = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: compare each handed-off result against the scoreboard
    always @(negedge clk) begin
        res_t r;
        if (rst_n && bus.o_valid && bus.i_ready && !bus.i_clear) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got sum %0d, expected no result at %0t",
                         sum_now(), $time);
            end else begin
                r = exp_q.pop_front();
                check("sb_sum", sum_now(), r.sum);
                check("sb_sat", longint'(bus.o_sat), longint'(r.sat));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted
    task automatic send(input logic [IN_W-1:0] p);
        int n;
        n = 0;
        bus.i_valid = 1'b1;
        bus.i_prod  = p;
        @(negedge clk);
        while (!bus.o_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("send_ready", longint'(bus.o_ready), 1);
        tick();
        bus.i_valid = 1'b0;
    endtask

    // Result held under backpressure, then released
    task automatic expect_result(input longint s, input bit sat);
        @(negedge clk);
        check("res_valid", longint'(bus.o_valid), 1);
        check("res_sum", sum_now(), s);
        check("res_sat", longint'(bus.o_sat), longint'(sat));
        tick();
        bus.i_ready = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_clear = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_prod  = '0;
        bus.i_ready = 1'b1;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check("rst_valid", longint'(bus.o_valid), 0);
        check("rst_sum", sum_now(), 0);
        check("rst_sat", longint'(bus.o_sat), 0);
        check("rst_ready", longint'(bus.o_ready), 1);
        tick();

        // Basic vector, back-to-back beats
        bus.i_ready = 1'b0;
        send(100); send(-50); send(25); send(7);
        expect_result(82, 1'b0);

        // Backpressure, then handoff and accept in the same cycle
        bus.i_ready = 1'b0;
        send(10); send(20); send(30); send(40);
        repeat (3) begin
            @(negedge clk);
            check("bp_valid", longint'(bus.o_valid), 1);
            check("bp_sum", sum_now(), 100);
            check("bp_ready", longint'(bus.o_ready), 0);
        end
        tick();
        bus.i_ready = 1'b1;
        send(5); send(1); send(1);
        bus.i_ready = 1'b0;
        send(1);
        expect_result(8, 1'b0);

        // Positive overflow
        bus.i_ready = 1'b0;
        repeat (4) send(32'h7FFF_FFFF);
`ifdef LOG_MULT_ACCUM_SAT_EN
        expect_result(64'sd4294967295, 1'b1);
`else
        expect_result(-4, 1'b0);
`endif

        // Negative overflow
        bus.i_ready = 1'b0;
        repeat (4) send(32'h8000_0000);
`ifdef LOG_MULT_ACCUM_SAT_EN
        expect_result(-64'sd4294967296, 1'b1);
`else
        expect_result(0, 1'b0);
`endif

        // Clear mid-vector, with a beat offered in the clear cycle
        send(9); send(9);
        bus.i_clear = 1'b1; bus.i_valid = 1'b1; bus.i_prod = 99;
        tick();
        bus.i_clear = 1'b0; bus.i_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("clr_no_valid", longint'(bus.o_valid), 0);
        end
        tick();
        bus.i_ready = 1'b0;
        repeat (4) send(1);
        expect_result(4, 1'b0);

        // Clear while a result is pending
        bus.i_ready = 1'b0;
        repeat (4) send(6);
        @(negedge clk);
        check("clr_done_valid", longint'(bus.o_valid), 1);
        tick();
        bus.i_clear = 1'b1; bus.i_valid = 1'b1; bus.i_prod = 99;
        tick();
        bus.i_clear = 1'b0; bus.i_valid = 1'b0;
        @(negedge clk);
        check("clr_done_drop", longint'(bus.o_valid), 0);
        check("clr_sum_hold", sum_now(), 24);
        tick();
        bus.i_ready = 1'b0;
        repeat (4) send(2);
        expect_result(8, 1'b0);

        // Asynchronous reset while a result is held
        bus.i_ready = 1'b0;
        repeat (4) send(7);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", longint'(bus.o_valid), 0);
        check("arst_sum", sum_now(), 0);
        check("arst_sat", longint'(bus.o_sat), 0);
        check("arst_ready", longint'(bus.o_ready), 1);
        @(posedge clk);
        tick();
        rst_n = 1'b1;
        tick();

        // Asynchronous reset mid-vector, then a fresh vector
        send(3); send(50);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mid_valid", longint'(bus.o_valid), 0);
        @(posedge clk);
        tick();
        rst_n = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        repeat (4) send(3);
        expect_result(12, 1'b0);

        // Randomized traffic with random backpressure and occasional clears
        for (int i = 0; i < 600; i++) begin
            bus.i_valid = ($urandom_range(3) != 0);
            bus.i_prod  = ($urandom_range(1) == 1) ? $urandom
                                                   : (32'($urandom_range(200)) - 32'd100);
            bus.i_ready = ($urandom_range(2) != 0);
            bus.i_clear = ($urandom_range(40) == 0);
            tick();
        end
        bus.i_valid = 1'b0;
        bus.i_clear = 1'b0;
        bus.i_ready = 1'b1;
        repeat (5) tick();
        check("queue_drained", longint'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/log_mult_accum.md
# log_mult_accum

Streaming accumulator placed directly downstream of the signed 16x16 logarithmic (Mitchell) multiplier. It consumes one 32-bit signed product per accepted beat and sums `LEN` consecutive products into a dot-product result. It presents each result on a valid/ready output port with full backpressure. It is the reduction stage of the log-MAC datapath, and overflow behaviour is selectable at compile time.

## Interface
- `IN_W`, default 32: product width; matches the multiplier's `o_z`.
- `ACC_W`, default 40: accumulator and result width; must be >= `IN_W`.
- `LEN`, default 8: products per result; must be >= 1.
- `i_clk`, in, 1: clock.
- `i_rst_n`, in, 1: asynchronous active-low reset.
- `i_clear`, in, 1: synchronous abort of the partial vector and any pending result.
- `i_valid`, in, 1: `i_prod` is valid.
- `i_prod`, in, `IN_W`: signed product from the multiplier.
- `o_ready`, out, 1: beat accepted when `i_valid && o_ready`.
- `o_valid`, out, 1: result valid.
- `o_sum`, out, `ACC_W`: signed result.
- `o_sat`, out, 1: result saturated at least once during its vector.
- `i_ready`, in, 1: downstream accepts the result when `o_valid && i_ready`.

## Operation
- **States**
  - IDLE: no partial sum.
  - ACC: 1..`LEN`-1 products summed.
  - DONE: result held on the output.
- **Beat counter** `cnt`, 0..`LEN`-1.
- **Accepted beat**
  - `i_prod` is sign-extended to `ACC_W`.
  - If `cnt==0`, the accumulator loads the product. Otherwise the accumulator adds the product to its current value.
  - The per-vector sat flag follows the same pattern: it loads this add's overflow when `cnt==0`, otherwise it ORs it in.
- **Transitions**
  - IDLE goes to ACC on an accept (`LEN>1`).
  - ACC stays in ACC while `cnt<LEN-1`.
  - An accept with `cnt==LEN-1` goes to DONE. On that edge `o_sum`, `o_sat` and `o_valid` are registered, and `cnt` wraps to 0.
  - With `LEN==1`, every accept goes straight to DONE.
- **DONE**
  - `o_valid=1`.
  - `o_sum` and `o_sat` are stable until the handoff.
  - `o_ready = i_ready`, so the first beat of the next vector can be accepted in the same cycle as the handoff.
- **Handoff** (`o_valid && i_ready`)
  - With no simultaneous accept: next state IDLE, `o_valid` deasserts.
  - With a simultaneous accept: the beat becomes element 0 of the next vector. Next state is ACC, or DONE again if `LEN==1`.
- **Ready outside DONE**: `o_ready=1` in IDLE and ACC.
- **`i_clear` has priority over everything**
  - Next state IDLE, `cnt=0`, accumulator 0.
  - `o_valid=0`; a pending result is discarded.
  - Any `i_prod` presented that cycle is dropped.
  - `o_sum` keeps its last value.
- **Held values**: `o_sum` and `o_sat` hold after handoff until the next result is registered.

## Timing
- **Reset values**: state IDLE, `cnt=0`, accumulator 0, `o_valid=0`, `o_sum=0`, `o_sat=0`.
- **`o_ready` after reset**: `o_ready=1` from the first cycle after `i_rst_n` deasserts.
- **Reset mid-vector or mid-DONE**: everything returns to reset values immediately, asynchronously.
- **Latency**: `o_valid` rises on the clock edge that accepts the `LEN`-th product, one cycle later.
- **Throughput**: one product per cycle, sustained with no bubble between vectors while `i_ready=1`.
- **`o_ready` path**: `o_ready` is combinational from `i_ready` in DONE. There is no combinational path from `i_valid` to `o_ready`.
- **Output registers**: `o_valid`, `o_sum` and `o_sat` are registered outputs.

## Configuration
- Macro: `LOG_MULT_ACCUM_SAT_EN`.
- **Defined**: each add clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. A clamping add sets the vector's sat flag, and accumulation continues from the clamped value.
- **Undefined**: two's-complement wrap modulo 2^`ACC_W`, and `o_sat` is tied to 0.

## Test plan
- **Basic vector**: `LEN=4`, back-to-back products 100, -50, 25, 7 -> `o_valid` one cycle after the 4th accept, `o_sum=82`, `o_sat=0`.
- **Backpressure and handoff**: `i_ready=0` for 3 cycles in DONE -> `o_valid=1`, `o_sum` stable, `o_ready=0`. Then `i_ready=1` with `i_valid=1`, `i_prod=5` -> handoff and accept in the same cycle; the next vector begins with 5.
- **Saturation, positive**: `ACC_W=33`, `LEN=4`, four beats of 0x7FFFFFFF.
  - With macro defined: `o_sum=4294967295`, `o_sat=1`.
  - Without macro: `o_sum=-4`, `o_sat=0`.
- **Saturation, negative**: same config, four beats of 0x80000000 with macro defined -> `o_sum=-4294967296`, `o_sat=1`.
- **Clear**: `i_clear` after 2 of 4 beats -> `o_valid` stays 0. The next 4 beats of 1 give `o_sum=4`. `i_clear` in DONE drops `o_valid` the next cycle.
- **Async reset**: assert `i_rst_n=0` mid-vector between edges -> all outputs go to reset values without a clock edge. After release, the 4-beat vector 3, 3, 3, 3 gives `o_sum=12`.
